// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Glyphs are held active-high as g..a; output polarity is applied later in the top.
package seg7_pkg;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    localparam logic [6:0] DASH_GLYPH = 7'b1000000;

    typedef struct packed {
        logic       valid;
        logic       dp;
        logic [3:0] val;
    } digit_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Value-to-glyph decoder, active-high segments g..a; blank digits light nothing.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] val,
    input  logic       valid,
    input  logic       hex_mode,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = 7'b0000000;
        if (valid) begin
            if (!hex_mode && (val > 4'd9)) begin
                glyph = DASH_GLYPH;
            end else begin
                glyph = GLYPH[val];
            end
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit time-multiplexed seven-segment controller with latched per-digit registers.
// Output registers load from next-state values so led/anode always line up with cnt/scan_idx.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 10000,
    parameter int GUARD_CYCLES   = 1,
    parameter int HEX_MODE       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IW            = idx_width(NUM_DIGITS),
    localparam int CW            = idx_width(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIGITS-1:0] wr_en,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  clear,
    output logic [6:0]            led,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [IW-1:0]         scan_idx
);

    localparam logic [6:0]            SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic                  DP_MASK  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic                  HEX_EN   = (HEX_MODE != 0);

    digit_t [NUM_DIGITS-1:0] digits_q;
    digit_t [NUM_DIGITS-1:0] digits_nxt;
    logic   [CW-1:0]         cnt_q;
    logic   [CW-1:0]         cnt_nxt;
    logic   [IW-1:0]         idx_q;
    logic   [IW-1:0]         idx_nxt;

    digit_t                  disp;
    logic                    guard;
    logic   [6:0]            glyph;
    logic   [NUM_DIGITS-1:0] an_sel;

    logic   [6:0]            led_q;
    logic                    dp_q;
    logic   [NUM_DIGITS-1:0] anode_q;

    // Clear beats any simultaneous write; reset is handled in the register block.
    always_comb begin
        digits_nxt = digits_q;
        cnt_nxt    = cnt_q;
        idx_nxt    = idx_q;

        if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_nxt[i] = '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en[i]) begin
                    digits_nxt[i] = {1'b1, wr_dp, wr_data};
                end
            end
        end

        if (cnt_q == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_nxt = cnt_q + 1'b1;
        end
    end

    always_comb begin
        disp   = digits_nxt[idx_nxt];
        guard  = (int'(cnt_nxt) < GUARD_CYCLES);
        an_sel = NUM_DIGITS'(1) << idx_nxt;
    end

    seg7_decoder u_decoder (
        .val      (disp.val),
        .valid    (disp.valid),
        .hex_mode (HEX_EN),
        .glyph    (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            led_q    <= SEG_MASK;
            dp_q     <= DP_MASK;
            anode_q  <= AN_MASK;
        end else begin
            digits_q <= digits_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            if (guard) begin
                led_q   <= SEG_MASK;
                dp_q    <= DP_MASK;
                anode_q <= AN_MASK;
            end else begin
                led_q   <= glyph ^ SEG_MASK;
                dp_q    <= (disp.valid & disp.dp) ^ DP_MASK;
                anode_q <= an_sel ^ AN_MASK;
            end
        end
    end

    assign led      = led_q;
    assign dp       = dp_q;
    assign anode    = anode_q;
    assign scan_idx = idx_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised N-digit, time-multiplexed seven-segment display controller with per-digit latched registers. It is the successor to the fixed 4-digit switch-driven display top. Generalisations: NUM_DIGITS digits, binary digit input (replacing one-hot), hex or decimal glyph mode, per-digit blank and decimal point, and an anode guard interval against ghosting. It sits between board switch/logic sources and the board's led/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
REFRESH_DIV, 10000, clk cycles per digit slot (> GUARD_CYCLES)
GUARD_CYCLES, 1, cycles at slot start with all anodes inactive (0 disables)
HEX_MODE, 1, 1: values 0-F shown as hex; 0: values 10-15 shown as "-" (segment g only)
SEG_ACTIVE_LOW, 1, led polarity
AN_ACTIVE_LOW, 1, anode polarity

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
wr_en  input  NUM_DIGITS  per-digit write strobe; bit i writes digit i
wr_data  input  4  binary digit value written on wr_en
wr_dp  input  1  decimal point written alongside wr_data
clear  input  1  synchronous blank of all digit registers
led  output  7  segments, led[0]=a … led[6]=g
dp  output  1  decimal point segment, same polarity as led
anode  output  NUM_DIGITS  digit enables; anode[0] = rightmost digit
scan_idx  output  clog2(NUM_DIGITS) (min 1)  index of digit slot currently scanned

Behaviour:
- Per-digit state: val[3:0], dp bit, valid bit (0 = blank). Reset and clear set val=0, dp=0, valid=0.
- Write priority: rst > clear > wr_en. Every set wr_en bit loads wr_data/wr_dp and sets valid=1. Multiple bits set in one cycle write the same data to every selected digit.
- Slot counter cnt counts 0..REFRESH_DIV-1.
  - At cnt=REFRESH_DIV-1: cnt wraps to 0, and scan_idx advances (NUM_DIGITS-1 wraps to 0).
  - NUM_DIGITS=1: scan_idx stays 0.
- All outputs are registered.
  - During rst and in the cycle it is sampled: anodes inactive, led/dp inactive, cnt=0, scan_idx=0.
- After rst release, slot 0 begins. In every slot:
  - For cnt < GUARD_CYCLES: all anodes inactive, led/dp inactive.
  - Otherwise: anode[scan_idx] active, all other anodes inactive; led/dp show digit scan_idx.
- Latency: a write to the digit being displayed appears on led/dp one cycle after the write cycle (register-to-register). A reset mid-slot aborts the slot immediately.
- Blank digit (valid=0): anode still driven in its slot, all segments and dp inactive.
- Glyphs in active-high form (g..a), for 0-F: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111, 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.
  - HEX_MODE=0 and val>9: 1000000.
  - SEG_ACTIVE_LOW inverts led and dp. AN_ACTIVE_LOW inverts anode.
- cnt width is clog2(REFRESH_DIV). There are no combinational paths from inputs to outputs.

Decomposition:
- Package seg7_pkg holds:
  - glyph constant array GLYPH[16] (active-high)
  - DASH_GLYPH constant
  - digit register struct typedef {valid, dp, val[3:0]}
  - helper function idx_width(n) returning max(1, clog2(n))
- One natural combinational sub-module: seg7_decoder (val, valid, hex_mode -> 7-bit active-high glyph).
- Polarity inversion and output registers live in seg7_scan_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=1, default polarities.
1. Hold rst 3 cycles, then release. During rst: anode=1111, led=1111111, dp=1. After release, slot 0 displays blank: anode=1110 from cnt=1, led=1111111.
2. wr_en=0001, wr_data=0, wr_dp=1 during slot 0. Next cycle: led=1000000, dp=0. After 8 cycles: scan_idx=1, and anode=1111 for 1 cycle, then 1101.
3. wr_en=1010, wr_data=4'hB. Digits 1 and 3 both show led=0000011 in their slots.
4. Rebuild with HEX_MODE=0 and write wr_data=4'hB to digit 2. In slot 2: led=0111111 (dash).
5. Write all digits, then assert clear for 1 cycle mid-slot while wr_en=1111. Clear wins: all slots blank (led=1111111), anodes still scan.
6. Assert rst at cnt=5 of slot 2. The next cycle has anode=1111. After release, scan restarts at scan_idx=0 with cnt=0, and all digits are blank.
